// File: rtl/div_seq_ctrl_if.sv
// Handshake and operand/result bundle between the multdiv front end (master)
// and the sequential divider (slave).
interface div_seq_ctrl_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             result_ready;
  logic             exception;
  logic             busy;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, result_ready, exception, busy
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, result_ready, exception, busy
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Sequential signed restoring divider: one trial-subtract step per clock, then sign fix.
// Define DIV_REMAINDER_EN to build the remainder path; otherwise remainder reads 0.
module div_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic         clock,
  input  logic         reset_n,
  div_seq_ctrl_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

  state_t               state, state_nx;
  logic [2*WIDTH-1:0]   aq;
  logic [WIDTH-1:0]     m;
  logic [WIDTH-1:0]     quotient_q;
  logic [CW-1:0]        count;
  logic                 q_neg;
  logic                 exception_q;
  logic                 accept;
  logic                 div_zero;
  logic [2*WIDTH-1:0]   s;
  logic [WIDTH:0]       t;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  // Unsigned 33-bit trial subtract: the borrow bit stays correct for |0x80000000|.
  always_comb begin
    s        = aq << 1;
    t        = {1'b0, s[2*WIDTH-1:WIDTH]} - {1'b0, m};
    accept   = (state == IDLE) && bus.start;
    div_zero = (bus.divisor == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx         = state;
    bus.result_ready = 1'b0;
    bus.busy         = 1'b0;
    case (state)
      IDLE: if (accept) state_nx = div_zero ? DONE : RUN;
      RUN: begin
        bus.busy = 1'b1;
        if (count == CW'(WIDTH - 1)) state_nx = FIX;
      end
      FIX: begin
        bus.busy = 1'b1;
        state_nx = DONE;
      end
      DONE: begin
        bus.busy         = 1'b1;
        bus.result_ready = 1'b1;
        state_nx         = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      aq          <= '0;
      m           <= '0;
      count       <= '0;
      q_neg       <= 1'b0;
      quotient_q  <= '0;
      exception_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) begin
              quotient_q  <= '0;
              exception_q <= 1'b1;
            end else begin
              aq    <= {{WIDTH{1'b0}}, mag(bus.dividend)};
              m     <= mag(bus.divisor);
              q_neg <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
              count <= '0;
            end
          end
        end
        RUN: begin
          aq    <= t[WIDTH] ? s : {t[WIDTH-1:0], s[WIDTH-1:1], 1'b1};
          count <= count + CW'(1);
        end
        FIX: begin
          quotient_q  <= q_neg ? -aq[WIDTH-1:0] : aq[WIDTH-1:0];
          exception_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.quotient  = quotient_q;
  assign bus.exception = exception_q;

`ifdef DIV_REMAINDER_EN
  logic             r_neg;
  logic [WIDTH-1:0] remainder_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_neg       <= 1'b0;
      remainder_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            if (div_zero) remainder_q <= '0;
            else          r_neg       <= bus.dividend[WIDTH-1];
          end
        end
        FIX:     remainder_q <= r_neg ? -aq[2*WIDTH-1:WIDTH] : aq[2*WIDTH-1:WIDTH];
        default: ;
      endcase
    end
  end

  assign bus.remainder = remainder_q;
`else
  assign bus.remainder = '0;
`endif

endmodule

// File: tb/tb_div_seq_ctrl.sv
// Directed self-checking bench for div_seq_ctrl; remainder expectations follow DIV_REMAINDER_EN.
module tb_div_seq_ctrl;

`ifdef DIV_REMAINDER_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic clock;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  div_seq_ctrl_if #(.WIDTH(32)) bus ();

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] exp_rem(input logic [31:0] r);
    return REM_EN ? r : 32'h0;
  endfunction

  // Issues one start, then watches for result_ready; lat counts E0's cycle as 1.
  // A start with 1/1 is driven during the result_ready cycle to confirm it is ignored.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input int inject_at,
                         output logic [31:0] q, output logic [31:0] r, output logic ex,
                         output int lat, output int busy_cycles,
                         output logic rr_after, output logic busy_after,
                         output logic [31:0] q_after);
    @(posedge clock); #1;
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clock); #1;
    bus.start = 1'b0;
    lat = 0; busy_cycles = 0; q = 'x; r = 'x; ex = 1'bx;
    for (int i = 0; i < 100; i++) begin
      if (bus.busy === 1'b1) busy_cycles++;
      if (bus.result_ready === 1'b1) begin
        lat = i + 1;
        q = bus.quotient; r = bus.remainder; ex = bus.exception;
        break;
      end
      if (i == inject_at) begin
        bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clock); #1;
    end
    bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1;
    @(posedge clock); #1;
    bus.start = 1'b0;
    rr_after = bus.result_ready; busy_after = bus.busy; q_after = bus.quotient;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    repeat (3) @(posedge clock);
    #1;
    n_checks++; if (bus.quotient !== 32'h0) begin n_fail++; $display("FAIL reset_quotient: got %h expected %h", bus.quotient, 32'h0); end
    n_checks++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL reset_remainder: got %h expected %h", bus.remainder, 32'h0); end
    n_checks++; if (bus.result_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", bus.result_ready); end
    n_checks++; if (bus.exception !== 1'b0) begin n_fail++; $display("FAIL reset_exception: got %b expected 0", bus.exception); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset_n = 1'b1;
  endtask

  task automatic test_basic_div();
    logic [31:0] q, r, qa; logic ex, rra, ba; int lat, bc;
    run_div(32'd100, 32'd7, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL basic_latency: got %0d expected 34", lat); end
    n_checks++; if (bc !== 34) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d expected 34", bc); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL basic_quotient: got %h expected %h", q, 32'd14); end
    n_checks++; if (r !== exp_rem(32'd2)) begin n_fail++; $display("FAIL basic_remainder: got %h expected %h", r, exp_rem(32'd2)); end
    n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL basic_exception: got %b expected 0", ex); end
    n_checks++; if (rra !== 1'b0) begin n_fail++; $display("FAIL basic_ready_one_cycle: got %b expected 0", rra); end
    n_checks++; if (ba !== 1'b0) begin n_fail++; $display("FAIL start_on_ready_ignored: busy got %b expected 0", ba); end
    n_checks++; if (qa !== 32'd14) begin n_fail++; $display("FAIL basic_quotient_hold: got %h expected %h", qa, 32'd14); end
  endtask

  task automatic test_signed_div();
    logic [31:0] q, r, qa; logic ex, rra, ba; int lat, bc;
    run_div(32'hFFFF_FF9C, 32'd7, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (q !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL negdvd_quotient: got %h expected %h", q, 32'hFFFF_FFF2); end
    n_checks++; if (r !== exp_rem(32'hFFFF_FFFE)) begin n_fail++; $display("FAIL negdvd_remainder: got %h expected %h", r, exp_rem(32'hFFFF_FFFE)); end
    run_div(32'd100, 32'hFFFF_FFF9, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (q !== 32'hFFFF_FFF2) begin n_fail++; $display("FAIL negdvs_quotient: got %h expected %h", q, 32'hFFFF_FFF2); end
    n_checks++; if (r !== exp_rem(32'd2)) begin n_fail++; $display("FAIL negdvs_remainder: got %h expected %h", r, exp_rem(32'd2)); end
    run_div(32'd0, 32'd5, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL zero_dvd_latency: got %0d expected 34", lat); end
    n_checks++; if (q !== 32'd0) begin n_fail++; $display("FAIL zero_dvd_quotient: got %h expected 0", q); end
    n_checks++; if (r !== 32'd0) begin n_fail++; $display("FAIL zero_dvd_remainder: got %h expected 0", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r, qa; logic ex, rra, ba; int lat, bc;
    run_div(32'h8000_0000, 32'hFFFF_FFFF, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL ovf_quotient: got %h expected %h", q, 32'h8000_0000); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL ovf_remainder: got %h expected 0", r); end
    n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL ovf_exception: got %b expected 0", ex); end
    run_div(32'h8000_0000, 32'd1, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (q !== 32'h8000_0000) begin n_fail++; $display("FAIL minint_div1_quotient: got %h expected %h", q, 32'h8000_0000); end
    run_div(32'h7FFF_FFFF, 32'h8000_0000, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL max_by_min_quotient: got %h expected 0", q); end
    n_checks++; if (r !== exp_rem(32'h7FFF_FFFF)) begin n_fail++; $display("FAIL max_by_min_remainder: got %h expected %h", r, exp_rem(32'h7FFF_FFFF)); end
  endtask

  task automatic test_div_zero();
    logic [31:0] q, r, qa; logic ex, rra, ba; int lat, bc;
    run_div(32'd5, 32'd0, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL dz_latency: got %0d expected 1", lat); end
    n_checks++; if (bc !== 1) begin n_fail++; $display("FAIL dz_busy_cycles: got %0d expected 1", bc); end
    n_checks++; if (ex !== 1'b1) begin n_fail++; $display("FAIL dz_exception: got %b expected 1", ex); end
    n_checks++; if (q !== 32'h0) begin n_fail++; $display("FAIL dz_quotient: got %h expected 0", q); end
    n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL dz_remainder: got %h expected 0", r); end
    n_checks++; if (bus.exception !== 1'b1) begin n_fail++; $display("FAIL dz_exception_hold: got %b expected 1", bus.exception); end
    run_div(32'd9, 32'd3, -1, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (ex !== 1'b0) begin n_fail++; $display("FAIL dz_clear_exception: got %b expected 0", ex); end
    n_checks++; if (q !== 32'd3) begin n_fail++; $display("FAIL dz_next_quotient: got %h expected %h", q, 32'd3); end
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL dz_next_latency: got %0d expected 34", lat); end
  endtask

  task automatic test_start_while_busy();
    logic [31:0] q, r, qa; logic ex, rra, ba; int lat, bc;
    run_div(32'd100, 32'd7, 3, q, r, ex, lat, bc, rra, ba, qa);
    n_checks++; if (lat !== 34) begin n_fail++; $display("FAIL busy_start_latency: got %0d expected 34", lat); end
    n_checks++; if (q !== 32'd14) begin n_fail++; $display("FAIL busy_start_quotient: got %h expected %h", q, 32'd14); end
    n_checks++; if (r !== exp_rem(32'd2)) begin n_fail++; $display("FAIL busy_start_remainder: got %h expected %h", r, exp_rem(32'd2)); end
  endtask

  task automatic test_reset_mid_op();
    int seen_ready;
    @(posedge clock); #1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    @(posedge clock); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", bus.busy); end
    n_checks++; if (bus.quotient !== 32'h0) begin n_fail++; $display("FAIL midrst_quotient: got %h expected 0", bus.quotient); end
    n_checks++; if (bus.remainder !== 32'h0) begin n_fail++; $display("FAIL midrst_remainder: got %h expected 0", bus.remainder); end
    n_checks++; if (bus.exception !== 1'b0) begin n_fail++; $display("FAIL midrst_exception: got %b expected 0", bus.exception); end
    @(posedge clock); #1;
    reset_n = 1'b1;
    seen_ready = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.result_ready !== 1'b0 || bus.busy !== 1'b0) seen_ready++;
      @(posedge clock); #1;
    end
    n_checks++; if (seen_ready !== 0) begin n_fail++; $display("FAIL midrst_no_result: got %0d active cycles expected 0", seen_ready); end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic_div();
    test_signed_div();
    test_overflow();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_op();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
